// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x32 four-write-port register file and its write scheduler.
package regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NPORT  = 4;
  localparam int unsigned PTR_W  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Population count of a port-wide vector; at most NPORT-1 bits are ever set when used for denials.
  function automatic logic [PTR_W-1:0] count_ones(input logic [NPORT-1:0] vec);
    logic [PTR_W:0] acc;
    acc = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      acc = acc + (PTR_W+1)'(vec[i]);
    end
    return PTR_W'(acc);
  endfunction

endpackage

// File: rtl/rr_conflict_arbiter.sv
// Combinational same-address conflict arbiter: grants every valid request not shadowed by a
// higher-priority valid request to the same address, priority rotating from rr_ptr_i.
module rr_conflict_arbiter
  import regfile_pkg::NPORT;
  import regfile_pkg::PTR_W;
  import regfile_pkg::count_ones;
#(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [NPORT-1:0]             valid_i,
  input  logic [NPORT-1:0][ADDR_W-1:0] addr_i,
  input  logic [PTR_W-1:0]             rr_ptr_i,
  output logic [NPORT-1:0]             grant_o,
  output logic [PTR_W-1:0]             denied_cnt_o
);

  // Distance from the pointer; smaller distance means higher priority.
  function automatic logic [PTR_W-1:0] rank(input int unsigned idx, input logic [PTR_W-1:0] ptr);
    return PTR_W'(idx) - ptr;
  endfunction

  always_comb begin
    grant_o      = '0;
    denied_cnt_o = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int unsigned j = 0; j < NPORT; j++) begin
        if ((j != i) && valid_i[j] && (addr_i[j] == addr_i[i]) &&
            (rank(j, rr_ptr_i) < rank(i, rr_ptr_i))) begin
          blocked = 1'b1;
        end
      end
      grant_o[i] = valid_i[i] && !blocked;
    end
    denied_cnt_o = count_ones(valid_i & ~grant_o);
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Write-side scheduler for the four-write-port register file: arbitrates requesters, fills idle
// slots with a copy of a granted write, and registers the shared-we write port bundle.
module regfile_write_scheduler
  import regfile_pkg::NPORT;
  import regfile_pkg::PTR_W;
#(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORT-1:0]  req_valid,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [ADDR_W-1:0] req_addr_2,
  input  logic [ADDR_W-1:0] req_addr_3,
  input  logic [DATA_W-1:0] req_data_0,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic [DATA_W-1:0] req_data_3,
  output logic [NPORT-1:0]  req_ready,
  output logic [ADDR_W-1:0] add_a,
  output logic [ADDR_W-1:0] add_b,
  output logic [ADDR_W-1:0] add_c,
  output logic [ADDR_W-1:0] add_d,
  output logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] din_c,
  output logic [DATA_W-1:0] din_d,
  output logic              we,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [NPORT-1:0][ADDR_W-1:0] addr_in;
  logic [NPORT-1:0][DATA_W-1:0] data_in;
  logic [NPORT-1:0]             grant;
  logic [PTR_W-1:0]             denied_cnt;

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NPORT-1:0][ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [NPORT-1:0][DATA_W-1:0] slot_data_q, slot_data_d;
  logic                         we_q, we_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  assign addr_in = {req_addr_3, req_addr_2, req_addr_1, req_addr_0};
  assign data_in = {req_data_3, req_data_2, req_data_1, req_data_0};

  rr_conflict_arbiter #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .valid_i      (req_valid),
    .addr_i       (addr_in),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (grant),
    .denied_cnt_o (denied_cnt)
  );

  assign req_ready = reset ? '0 : grant;

  // Ungranted slots replicate the lowest-index granted write so the shared we is harmless.
  always_comb begin
    logic [PTR_W-1:0] fill_idx;
    logic [CNT_W:0]   cnt_sum;
    fill_idx    = '0;
    slot_addr_d = '0;
    slot_data_d = '0;
    we_d        = |grant;
    rr_ptr_d    = rr_ptr_q;
    cnt_sum     = '0;
    cnt_d       = cnt_q;

    for (int i = int'(NPORT) - 1; i >= 0; i--) begin
      if (grant[i]) begin
        fill_idx = PTR_W'(i);
      end
    end
    if (we_d) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        slot_addr_d[i] = grant[i] ? addr_in[i] : addr_in[fill_idx];
        slot_data_d[i] = grant[i] ? data_in[i] : data_in[fill_idx];
      end
    end

    if (denied_cnt != '0) begin
      rr_ptr_d = rr_ptr_q + PTR_W'(1);
    end

    // Saturating add: the extra MSB catches overflow and clamps to all-ones.
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(denied_cnt);
    cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
    end
  end

  assign add_a        = slot_addr_q[0];
  assign add_b        = slot_addr_q[1];
  assign add_c        = slot_addr_q[2];
  assign add_d        = slot_addr_q[3];
  assign din_a        = slot_data_q[0];
  assign din_b        = slot_data_q[1];
  assign din_c        = slot_data_q[2];
  assign din_d        = slot_data_q[3];
  assign we           = we_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: a priority-walk reference model predicts grants,
// port-slot contents and the conflict counter; a monitor pops expectations whenever we is high.
module tb_regfile_write_scheduler;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [3:0]    req_valid;
  logic [AW-1:0] req_addr_0, req_addr_1, req_addr_2, req_addr_3;
  logic [DW-1:0] req_data_0, req_data_1, req_data_2, req_data_3;
  logic [3:0]    req_ready;
  logic [AW-1:0] add_a, add_b, add_c, add_d;
  logic [DW-1:0] din_a, din_b, din_c, din_d;
  logic          we;
  logic [CW-1:0] conflict_cnt;

  regfile_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1), .req_addr_2(req_addr_2), .req_addr_3(req_addr_3),
    .req_data_0(req_data_0), .req_data_1(req_data_1), .req_data_2(req_data_2), .req_data_3(req_data_3),
    .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
    .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_d(din_d),
    .we(we), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] ad [4];
    logic [DW-1:0] dt [4];
  } wr_t;

  wr_t           sb_q[$];
  int            checks   = 0;
  int            failures = 0;

  logic          v [4];
  logic [AW-1:0] a [4];
  logic [DW-1:0] d [4];
  int            wait_c [4];
  int            m_ptr = 0;
  int            m_cnt = 0;
  logic          m_we  = 1'b0;
  logic [3:0]    last_ready;
  logic [DW-1:0] shadow [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, predict grants and the next state.
  task automatic do_cycle(input logic rst_in);
    logic [3:0]    g;
    logic [AW-1:0] seen [$];
    int            ndeny;
    int            low;
    wr_t           r;
    @(negedge clk);
    check("we", 64'(we), 64'(m_we));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    reset      = rst_in;
    req_valid  = {v[3], v[2], v[1], v[0]};
    req_addr_0 = a[0]; req_addr_1 = a[1]; req_addr_2 = a[2]; req_addr_3 = a[3];
    req_data_0 = d[0]; req_data_1 = d[1]; req_data_2 = d[2]; req_data_3 = d[3];
    #1;
    g = '0;
    seen.delete();
    if (!rst_in) begin
      for (int k = 0; k < 4; k++) begin
        int  i;
        bit  hit;
        i = (m_ptr + k) % 4;
        if (v[i]) begin
          hit = 1'b0;
          foreach (seen[s]) if (seen[s] == a[i]) hit = 1'b1;
          if (!hit) g[i] = 1'b1;
          seen.push_back(a[i]);
        end
      end
    end
    last_ready = req_ready;
    check("req_ready", 64'(req_ready), 64'(g));
    if (rst_in) begin
      m_ptr = 0;
      m_cnt = 0;
      m_we  = 1'b0;
      for (int i = 0; i < 4; i++) wait_c[i] = 0;
    end else begin
      ndeny = 0;
      for (int i = 0; i < 4; i++) if (v[i] && !g[i]) ndeny++;
      if (ndeny > 0) m_ptr = (m_ptr + 1) % 4;
      m_cnt = (m_cnt + ndeny > int'(CMAX)) ? int'(CMAX) : m_cnt + ndeny;
      m_we  = (g != 4'b0);
      if (g != 4'b0) begin
        low = 0;
        for (int i = 3; i >= 0; i--) if (g[i]) low = i;
        for (int i = 0; i < 4; i++) begin
          r.ad[i] = g[i] ? a[i] : a[low];
          r.dt[i] = g[i] ? d[i] : d[low];
        end
        sb_q.push_back(r);
      end
      for (int i = 0; i < 4; i++) begin
        if (v[i]) begin
          if (g[i]) begin
            check("fairness_wait_lt4", 64'(wait_c[i] < 4), 64'(1));
            wait_c[i] = 0;
            v[i] = 1'b0;
          end else begin
            wait_c[i]++;
          end
        end
      end
    end
  endtask

  // Monitor: commits last cycle's observed write to the shadow file, then scores the new one.
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_a [4];
  logic [DW-1:0] pend_d [4];

  always @(posedge clk) begin
    wr_t e;
    if (reset) begin
      for (int i = 0; i < 32; i++) shadow[i] = '0;
    end else if (pend_v) begin
      for (int i = 0; i < 4; i++) shadow[pend_a[i]] = pend_d[i];
    end
    pend_v = 1'b0;
    #2;
    if (we) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_write", 64'(we), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("add_a", 64'(add_a), 64'(e.ad[0]));
        check("add_b", 64'(add_b), 64'(e.ad[1]));
        check("add_c", 64'(add_c), 64'(e.ad[2]));
        check("add_d", 64'(add_d), 64'(e.ad[3]));
        check("din_a", 64'(din_a), 64'(e.dt[0]));
        check("din_b", 64'(din_b), 64'(e.dt[1]));
        check("din_c", 64'(din_c), 64'(e.dt[2]));
        check("din_d", 64'(din_d), 64'(e.dt[3]));
      end
      pend_a[0] = add_a; pend_a[1] = add_b; pend_a[2] = add_c; pend_a[3] = add_d;
      pend_d[0] = din_a; pend_d[1] = din_b; pend_d[2] = din_c; pend_d[3] = din_d;
      pend_v = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr_0 = '0; req_addr_1 = '0; req_addr_2 = '0; req_addr_3 = '0;
    req_data_0 = '0; req_data_1 = '0; req_data_2 = '0; req_data_3 = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1; a[i] = AW'(i + 20); d[i] = DW'(i); wait_c[i] = 0;
    end

    // Reset held with all requests valid.
    do_cycle(1'b1);
    do_cycle(1'b1);
    for (int i = 0; i < 4; i++) v[i] = 1'b0;

    // Four distinct addresses, all granted together.
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = DW'(32'h11 * (i + 1));
    end
    do_cycle(1'b0);
    check("noconf_ready", 64'(last_ready), 64'(4'b1111));
    do_cycle(1'b0);

    // Single requester replicated into all slots.
    v[2] = 1'b1; a[2] = AW'(7); d[2] = 32'hDEAD;
    do_cycle(1'b0);
    do_cycle(1'b0);
    do_cycle(1'b0);
    check("fill_reg7", 64'(shadow[7]), 64'(32'hDEAD));
    check("fill_reg1_untouched", 64'(shadow[1]), 64'(32'h11));

    // Four-way collision serialised by rotating priority.
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b1; a[i] = AW'(5); d[i] = DW'(32'hA0 + i);
    end
    do_cycle(1'b0);
    check("rot_grant0", 64'(last_ready), 64'(4'b0001));
    do_cycle(1'b0);
    check("rot_grant1", 64'(last_ready), 64'(4'b0010));
    do_cycle(1'b0);
    check("rot_grant2", 64'(last_ready), 64'(4'b0100));
    do_cycle(1'b0);
    check("rot_grant3", 64'(last_ready), 64'(4'b1000));
    do_cycle(1'b0);
    do_cycle(1'b0);
    check("rot_cnt", 64'(conflict_cnt), 64'(6));
    check("rot_reg5", 64'(shadow[5]), 64'(32'hA3));

    // Partial conflict from a fresh pointer.
    do_cycle(1'b1);
    v[0] = 1'b1; a[0] = AW'(9);  d[0] = 32'h90;
    v[1] = 1'b1; a[1] = AW'(9);  d[1] = 32'h91;
    v[2] = 1'b1; a[2] = AW'(10); d[2] = 32'h92;
    v[3] = 1'b1; a[3] = AW'(11); d[3] = 32'h93;
    do_cycle(1'b0);
    check("partial_ready", 64'(last_ready), 64'(4'b1101));
    do_cycle(1'b0);
    check("partial_add_b", 64'(add_b), 64'(9));
    check("partial_din_b", 64'(din_b), 64'(32'h90));
    check("partial_cnt", 64'(conflict_cnt), 64'(1));
    do_cycle(1'b0);

    // Reset arrives the cycle after an accepted write.
    do_cycle(1'b1);
    v[0] = 1'b1; a[0] = AW'(3); d[0] = 32'h3333;
    do_cycle(1'b0);
    v[1] = 1'b1; a[1] = AW'(4); d[1] = 32'h4444;
    do_cycle(1'b1);
    v[1] = 1'b0;
    do_cycle(1'b0);
    do_cycle(1'b0);
    check("rstmid_reg3", 64'(shadow[3]), 64'(0));

    // Randomised traffic over a narrow address range to force collisions and saturation.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && ($urandom % 10) < 6) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, 5));
          d[i] = DW'($urandom);
        end
      end
      do_cycle(($urandom % 60) == 0);
    end
    for (int i = 0; i < 4; i++) v[i] = 1'b0;
    do_cycle(1'b0);
    do_cycle(1'b0);
    do_cycle(1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
